// File: rtl/clk_div_pkg.sv
// Shared constants, channel state encoding and the load clamp for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned CLAMP_W   = 32;
  localparam int unsigned DEF_DIV   = 2;
  localparam int unsigned DEF_HIGH  = 1;

  typedef struct packed {
    logic [CLAMP_W-1:0] div_c;
    logic [CLAMP_W-1:0] high_c;
  } clamp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Divide is forced to at least 2; high time never exceeds the period.
  function automatic clamp_t clamp_div(input logic [CLAMP_W-1:0] div,
                                       input logic [CLAMP_W-1:0] high);
    clamp_t r;
    r.div_c  = (div < CLAMP_W'(2)) ? CLAMP_W'(2) : div;
    r.high_c = (high > r.div_c) ? r.div_c : high;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle of the divider bank: per-channel enables, load strobes, shared program bus, outputs.
interface clk_div_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
);
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  load;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] high_in;
  logic             sync_start;
  logic [N_CH-1:0]  CP_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  modport master (
    output en, load, div_in, high_in, sync_start,
    input  CP_out, tick, pend
  );

  modport slave (
    input  en, load, div_in, high_in, sync_start,
    output CP_out, tick, pend
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divide+duty, and boundary-only reprogramming.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int unsigned DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic             CP_in,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] div_ld_i,
  input  logic [CNT_W-1:0] high_ld_i,
  output logic             cp_o,
  output logic             tick_o,
  output logic             pend_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_a_q, div_a_d;
  logic [CNT_W-1:0] high_a_q, high_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d;
  logic [CNT_W-1:0] high_s_q, high_s_d;
  logic             pend_q, pend_d;
  logic             cp_q, cp_d;
  logic             tick_q, tick_d;

  logic             wrap_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] div_bnd_c;
  logic [CNT_W-1:0] high_bnd_c;

  assign wrap_c    = (state_q == ST_RUN) && (cnt_q == CNT_W'(div_a_q - CNT_W'(1)));
  assign cnt_inc_c = CNT_W'(cnt_q + CNT_W'(1));

  // Values the next period starts with: a load on the boundary beats a pending shadow.
  assign div_bnd_c  = load_i ? div_ld_i  : (pend_q ? div_s_q  : div_a_q);
  assign high_bnd_c = load_i ? high_ld_i : (pend_q ? high_s_q : high_a_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_a_d  = div_a_q;
    high_a_d = high_a_q;
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    pend_d   = pend_q;
    cp_d     = cp_q;
    tick_d   = 1'b0;

    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      cp_d    = 1'b0;
      if (load_i) begin
        div_a_d  = div_ld_i;
        high_a_d = high_ld_i;
        div_s_d  = div_ld_i;
        high_s_d = high_ld_i;
        pend_d   = 1'b0;
      end
    end else if ((state_q == ST_IDLE) || sync_i || wrap_c) begin
      // Start, resync and natural wrap all begin a fresh period.
      state_d  = ST_RUN;
      cnt_d    = '0;
      tick_d   = 1'b1;
      div_a_d  = div_bnd_c;
      high_a_d = high_bnd_c;
      pend_d   = 1'b0;
      cp_d     = (high_bnd_c != '0);
    end else begin
      cnt_d = cnt_inc_c;
      cp_d  = (cnt_inc_c < high_a_q);
      if (load_i) begin
        div_s_d  = div_ld_i;
        high_s_d = high_ld_i;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CP_in) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_a_q  <= CNT_W'(DEF_DIV);
      high_a_q <= CNT_W'(DEF_HIGH);
      div_s_q  <= CNT_W'(DEF_DIV);
      high_s_q <= CNT_W'(DEF_HIGH);
      pend_q   <= 1'b0;
      cp_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      pend_q   <= pend_d;
      cp_q     <= cp_d;
      tick_q   <= tick_d;
    end
  end

  assign cp_o   = cp_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock/strobe divider; clamps the shared program bus once and fans it out.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int unsigned DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic           CP_in,
  input  logic           reset,
  clk_div_bank_if.slave  bus
);

  clamp_t           clamp_c;
  logic [CNT_W-1:0] div_ld_c;
  logic [CNT_W-1:0] high_ld_c;
  logic [N_CH-1:0]  cp_w;
  logic [N_CH-1:0]  tick_w;
  logic [N_CH-1:0]  pend_w;

  // CNT_W is assumed <= CLAMP_W, so the narrowing casts below are lossless.
  assign clamp_c   = clamp_div(CLAMP_W'(bus.div_in), CLAMP_W'(bus.high_in));
  assign div_ld_c  = CNT_W'(clamp_c.div_c);
  assign high_ld_c = CNT_W'(clamp_c.high_c);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .CP_in     (CP_in),
      .reset     (reset),
      .en_i      (bus.en[g]),
      .load_i    (bus.load[g]),
      .sync_i    (bus.sync_start),
      .div_ld_i  (div_ld_c),
      .high_ld_i (high_ld_c),
      .cp_o      (cp_w[g]),
      .tick_o    (tick_w[g]),
      .pend_o    (pend_w[g])
    );
  end

  assign bus.CP_out = cp_w;
  assign bus.tick   = tick_w;
  assign bus.pend   = pend_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic against a period-level model.
module tb_clk_div_bank;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DDIV  = 2;
  localparam int unsigned DHIGH = 1;

  logic CP_in;
  logic reset;

  clk_div_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DDIV), .DEF_HIGH(DHIGH)
  ) dut (
    .CP_in (CP_in),
    .reset (reset),
    .bus   (bus)
  );

  initial CP_in = 1'b0;
  always #5 CP_in = ~CP_in;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: each channel is a position inside a period of length m_div, with a queued reprogram.
  int unsigned m_div [N_CH];
  int unsigned m_high[N_CH];
  int unsigned m_sdiv[N_CH];
  int unsigned m_shigh[N_CH];
  int unsigned m_pos [N_CH];
  bit          m_run [N_CH];
  bit          m_pend[N_CH];
  logic [N_CH-1:0] exp_cp, exp_tick, exp_pend;

  function automatic void model_step();
    int unsigned dc, hc;
    dc = 32'(bus.div_in);
    if (dc < 2) dc = 2;
    hc = 32'(bus.high_in);
    if (hc > dc) hc = dc;
    for (int c = 0; c < N_CH; c++) begin
      if (reset) begin
        m_run[c] = 0; m_pos[c] = 0; m_pend[c] = 0;
        m_div[c] = DDIV; m_high[c] = DHIGH; m_sdiv[c] = DDIV; m_shigh[c] = DHIGH;
      end else if (!bus.en[c]) begin
        m_run[c] = 0; m_pos[c] = 0;
        if (bus.load[c]) begin
          m_div[c] = dc; m_high[c] = hc; m_sdiv[c] = dc; m_shigh[c] = hc; m_pend[c] = 0;
        end
      end else if (!m_run[c] || bus.sync_start || (m_pos[c] + 1 == m_div[c])) begin
        if (bus.load[c]) begin
          m_div[c] = dc; m_high[c] = hc;
        end else if (m_pend[c]) begin
          m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c];
        end
        m_pend[c] = 0; m_run[c] = 1; m_pos[c] = 0;
      end else begin
        m_pos[c] = m_pos[c] + 1;
        if (bus.load[c]) begin
          m_sdiv[c] = dc; m_shigh[c] = hc; m_pend[c] = 1;
        end
      end
      exp_cp[c]   = m_run[c] && (m_pos[c] < m_high[c]);
      exp_tick[c] = m_run[c] && (m_pos[c] == 0);
      exp_pend[c] = m_pend[c];
    end
  endfunction

  task automatic cycle();
    @(posedge CP_in);
    model_step();
    @(negedge CP_in);
  endtask

  task automatic wait_tick0(output bit ok);
    int k;
    k = 0;
    while (!bus.tick[0] && k < 64) begin
      cycle();
      k++;
    end
    ok = bus.tick[0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = '0; bus.load = '0; bus.div_in = '0; bus.high_in = '0; bus.sync_start = 1'b0;
    cycle();
    cycle();
    n_vec++;
    if ({bus.CP_out, bus.tick, bus.pend} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs got cp=%b tick=%b pend=%b want all zero", bus.CP_out, bus.tick, bus.pend);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic e;
    bus.en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = (k % 2 == 0);
      n_vec++;
      if (bus.CP_out !== {3'b000, e} || bus.tick !== {3'b000, e}) begin
        n_miss++;
        $display("FAIL basic_div2 k=%0d got cp=%b tick=%b want cp/tick=%b", k, bus.CP_out, bus.tick, {3'b000, e});
      end
    end
  endtask

  task automatic test_reprogram();
    bit ok;
    logic ec, et;
    wait_tick0(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL reprog_wait got no tick want tick"); end
    bus.load = 4'b0001; bus.div_in = 16'd5; bus.high_in = 16'd2;
    cycle();
    bus.load = '0;
    n_vec++;
    if (bus.pend[0] !== 1'b1 || bus.CP_out[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL reprog_pend got pend=%b cp=%b want pend=1 cp=0", bus.pend[0], bus.CP_out[0]);
    end
    cycle();
    n_vec++;
    if (bus.tick[0] !== 1'b1 || bus.pend[0] !== 1'b0 || bus.CP_out[0] !== 1'b1) begin
      n_miss++;
      $display("FAIL reprog_apply got tick=%b pend=%b cp=%b want 1 0 1", bus.tick[0], bus.pend[0], bus.CP_out[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      cycle();
      ec = (k % 5 < 2); et = (k % 5 == 0);
      n_vec++;
      if (bus.CP_out[0] !== ec || bus.tick[0] !== et) begin
        n_miss++;
        $display("FAIL reprog_div5 k=%0d got cp=%b tick=%b want cp=%b tick=%b", k, bus.CP_out[0], bus.tick[0], ec, et);
      end
    end
  endtask

  task automatic test_duty_extremes();
    bit ok;
    logic [CNT_W-1:0] highs[2];
    highs[0] = 16'd3; highs[1] = 16'd0;
    for (int h = 0; h < 2; h++) begin
      wait_tick0(ok);
      bus.load = 4'b0001; bus.div_in = 16'd3; bus.high_in = highs[h];
      cycle();
      bus.load = '0;
      wait_tick0(ok);
      n_vec++;
      if (!ok) begin n_miss++; $display("FAIL duty_wait h=%0d got no tick want tick", h); end
      for (int k = 0; k < 6; k++) begin
        if (k > 0) cycle();
        n_vec++;
        if (bus.CP_out[0] !== (h == 0) || bus.tick[0] !== (k % 3 == 0) || bus.pend[0] !== 1'b0) begin
          n_miss++;
          $display("FAIL duty_h%0d k=%0d got cp=%b tick=%b pend=%b want cp=%b tick=%b pend=0",
                   h, k, bus.CP_out[0], bus.tick[0], bus.pend[0], (h == 0), (k % 3 == 0));
        end
      end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    wait_tick0(ok);
    bus.load = 4'b0001; bus.div_in = 16'd0; bus.high_in = 16'd9;
    cycle();
    bus.load = '0;
    wait_tick0(ok);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle();
      n_vec++;
      if (bus.CP_out[0] !== 1'b1 || bus.tick[0] !== (k % 2 == 0)) begin
        n_miss++;
        $display("FAIL clamp_div2 k=%0d got cp=%b tick=%b want cp=1 tick=%b", k, bus.CP_out[0], bus.tick[0], (k % 2 == 0));
      end
    end
    // Position 1 of a 2-cycle period: the next edge is the wrap.
    bus.load = 4'b0001; bus.div_in = 16'd4; bus.high_in = 16'd9;
    cycle();
    bus.load = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycle();
      n_vec++;
      if (bus.CP_out[0] !== 1'b1 || bus.tick[0] !== (k % 4 == 0) || bus.pend[0] !== 1'b0) begin
        n_miss++;
        $display("FAIL clamp_wrapload k=%0d got cp=%b tick=%b pend=%b want cp=1 tick=%b pend=0",
                 k, bus.CP_out[0], bus.tick[0], bus.pend[0], (k % 4 == 0));
      end
    end
  endtask

  task automatic test_sync();
    bus.en = '0;
    bus.load = 4'b0001; bus.div_in = 16'd4; bus.high_in = 16'd2;
    cycle();
    bus.load = 4'b0010; bus.div_in = 16'd6; bus.high_in = 16'd3;
    cycle();
    bus.load = '0;
    bus.en = 4'b0011;
    repeat (3) cycle();
    bus.sync_start = 1'b1;
    cycle();
    bus.sync_start = 1'b0;
    n_vec++;
    if (bus.tick !== 4'b0011) begin
      n_miss++;
      $display("FAIL sync_tick got tick=%b want 0011", bus.tick);
    end
    for (int k = 1; k <= 24; k++) begin
      cycle();
      n_vec++;
      if (bus.tick[0] !== (k % 4 == 0) || bus.tick[1] !== (k % 6 == 0) || bus.CP_out[0] !== (k % 4 < 2)
          || bus.CP_out[1] !== (k % 6 < 3)) begin
        n_miss++;
        $display("FAIL sync_align k=%0d got tick=%b cp=%b want tick0=%b tick1=%b", k, bus.tick, bus.CP_out,
                 (k % 4 == 0), (k % 6 == 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.en = 4'b0001;
    wait_tick0(ok);
    bus.load = 4'b0001; bus.div_in = 16'd7; bus.high_in = 16'd1;
    cycle();
    bus.load = '0;
    n_vec++;
    if (bus.pend[0] !== 1'b1) begin n_miss++; $display("FAIL rstmid_pend got pend=%b want 1", bus.pend[0]); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_vec++;
    if ({bus.CP_out, bus.tick, bus.pend} !== '0) begin
      n_miss++;
      $display("FAIL rstmid_zero got cp=%b tick=%b pend=%b want all zero", bus.CP_out, bus.tick, bus.pend);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_vec++;
      if (bus.CP_out[0] !== (k % 2 == 0) || bus.tick[0] !== (k % 2 == 0) || bus.pend[0] !== 1'b0) begin
        n_miss++;
        $display("FAIL rstmid_default k=%0d got cp=%b tick=%b pend=%b want cp/tick=%b pend=0",
                 k, bus.CP_out[0], bus.tick[0], bus.pend[0], (k % 2 == 0));
      end
    end
  endtask

  task automatic test_random();
    bus.en = 4'b1111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) bus.en[$urandom_range(0, N_CH-1)] = ~bus.en[$urandom_range(0, N_CH-1)];
      bus.load       = ($urandom_range(0, 4) == 0) ? N_CH'($urandom) : '0;
      bus.div_in     = CNT_W'($urandom_range(0, 9));
      bus.high_in    = CNT_W'($urandom_range(0, 11));
      bus.sync_start = ($urandom_range(0, 39) == 0);
      reset          = ($urandom_range(0, 299) == 0);
      cycle();
      n_vec++;
      if ({bus.CP_out, bus.tick, bus.pend} !== {exp_cp, exp_tick, exp_pend}) begin
        n_miss++;
        $display("FAIL random i=%0d got cp=%b tick=%b pend=%b want cp=%b tick=%b pend=%b",
                 i, bus.CP_out, bus.tick, bus.pend, exp_cp, exp_tick, exp_pend);
      end
    end
    reset = 1'b0;
    bus.load = '0;
    bus.sync_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reprogram();
    test_duty_extremes();
    test_clamp();
    test_sync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
